tlk2711_rx_deframer: RTL

Receive-side deframer for the TLK2711 parallel 16-bit link. It consumes the TLK2711 RXD/RKMSB/RKLSB bus in the rx_clk domain, acquires link sync on idle words, parses framed packets (SOF, header, payload, checksum, EOF) and streams payload words out. It reports per-frame pass/fail and keeps saturating good/bad frame counters. It is the far-end counterpart of the tlk2711 transmit path and sits between the tlk2711b_rx pins and downstream capture/DMA logic.

---
 rtl/tlk2711_rx_deframer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tlk2711_rx_deframer.sv
// tlk2711_rx_deframer: TLK2711 16-bit receive deframer with link sync, frame parsing and frame counters.
// Ports: clk/rst_n (sync active-low); i_rxd/i_rkmsb/i_rklsb TLK2711 RX bus; i_clr_cnt clears counters;
// o_link_up sync status; o_data/o_valid/o_sof/o_eof payload stream; o_type frame type;
// o_frame_done/o_frame_ok per-frame verdict pulse; o_ok_cnt/o_err_cnt saturating frame counters.
module tlk2711_rx_deframer #(
  parameter int MAX_LEN  = 1024,
  parameter int SYNC_CNT = 16,
  parameter int LOS_CNT  = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      i_rxd,
  input  logic             i_rkmsb,
  input  logic             i_rklsb,
  input  logic             i_clr_cnt,
  output logic             o_link_up,
  output logic [15:0]      o_data,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic [3:0]       o_type,
  output logic             o_frame_done,
  output logic             o_frame_ok,
  output logic [CNT_W-1:0] o_ok_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);
  localparam int SW = $clog2(SYNC_CNT + 1);
  localparam int RW = $clog2(LOS_CNT + 1);
  typedef enum logic [2:0] {S_UNSYNC, S_IDLE, S_HDR, S_PAYLOAD, S_CKSUM, S_EOF} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sync_q, sync_d;
  logic [RW-1:0] run_q, run_d;
  logic link_q, link_d, valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic done_q, done_d, ok_q, ok_d, pass_q, pass_d;
  logic [15:0] data_q, data_d, acc_q, acc_d;
  logic [3:0] type_q, type_d;
  logic [11:0] len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;
  logic is_idle, is_sof, is_eof, is_data, is_cerr, len_ok, ok_inc, err_inc, frame_err;
  assign is_idle = {i_rkmsb, i_rklsb} == 2'b01 && i_rxd == 16'hC5BC;
  assign is_sof  = {i_rkmsb, i_rklsb} == 2'b11 && i_rxd == 16'hFBFB;
  assign is_eof  = {i_rkmsb, i_rklsb} == 2'b11 && i_rxd == 16'hFDFD;
  assign is_data = {i_rkmsb, i_rklsb} == 2'b00;
  assign is_cerr = !(is_idle || is_sof || is_eof || is_data);
  assign len_ok  = i_rxd[11:0] != 12'd0 && i_rxd[11:0] <= 12'(MAX_LEN);
  always_comb begin
    state_d = state_q;
    sync_d = sync_q;
    run_d = run_q;
    link_d = link_q;
    data_d = data_q;
    type_d = type_q;
    len_d = len_q;
    idx_d = idx_q;
    acc_d = acc_q;
    pass_d = pass_q;
    valid_d = 1'b0;
    sof_d = 1'b0;
    eof_d = 1'b0;
    done_d = 1'b0;
    ok_d = 1'b0;
    ok_inc = 1'b0;
    err_inc = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_UNSYNC: begin
        sync_d = is_idle ? sync_q + 1'b1 : '0;
        if (is_idle && sync_q == SW'(SYNC_CNT - 1)) begin
          state_d = S_IDLE;
          link_d = 1'b1;
          sync_d = '0;
        end
      end
      S_IDLE: state_d = is_sof ? S_HDR : S_IDLE;
      S_HDR: begin
        if (is_data && len_ok) begin
          type_d = i_rxd[15:12];
          len_d = i_rxd[11:0];
          acc_d = i_rxd;
          idx_d = '0;
          state_d = S_PAYLOAD;
        end else frame_err = 1'b1;
      end
      S_PAYLOAD: begin
        if (is_data) begin
          data_d = i_rxd;
          valid_d = 1'b1;
          sof_d = idx_q == 12'd0;
          eof_d = idx_q == len_q - 12'd1;
          acc_d = acc_q + i_rxd;
          idx_d = idx_q + 12'd1;
          state_d = eof_d ? S_CKSUM : S_PAYLOAD;
        end else frame_err = 1'b1;
      end
      S_CKSUM: begin
        if (is_data) begin
          pass_d = i_rxd == acc_q;
          state_d = S_EOF;
        end else frame_err = 1'b1;
      end
      S_EOF: begin
        if (is_eof) begin
          done_d = 1'b1;
          ok_d = pass_q;
          ok_inc = pass_q;
          err_inc = !pass_q;
          state_d = S_IDLE;
        end else frame_err = 1'b1;
      end
      default: state_d = S_UNSYNC;
    endcase
    // An SOF arriving mid-frame aborts the old frame and starts parsing the new one.
    if (frame_err) begin
      done_d = 1'b1;
      err_inc = 1'b1;
      state_d = is_sof ? S_HDR : S_IDLE;
    end
    // Any code error mid-frame already raised the single abort pulse above, so loss of sync only drops the link.
    if (state_q != S_UNSYNC) begin
      run_d = is_cerr ? run_q + 1'b1 : '0;
      if (is_cerr && run_q == RW'(LOS_CNT - 1)) begin
        state_d = S_UNSYNC;
        link_d = 1'b0;
        run_d = '0;
        sync_d = '0;
      end
    end
    ok_cnt_d = i_clr_cnt ? '0 : ok_cnt_q + CNT_W'(ok_inc && !(&ok_cnt_q));
    err_cnt_d = i_clr_cnt ? '0 : err_cnt_q + CNT_W'(err_inc && !(&err_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_UNSYNC;
      sync_q <= '0;
      run_q <= '0;
      link_q <= 1'b0;
      data_q <= '0;
      type_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      pass_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      ok_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      run_q <= run_d;
      link_q <= link_d;
      data_q <= data_d;
      type_q <= type_d;
      len_q <= len_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      pass_q <= pass_d;
      valid_q <= valid_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      done_q <= done_d;
      ok_q <= ok_d;
      ok_cnt_q <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign o_link_up = link_q;
  assign o_data = data_q;
  assign o_valid = valid_q;
  assign o_sof = sof_q;
  assign o_eof = eof_q;
  assign o_type = type_q;
  assign o_frame_done = done_q;
  assign o_frame_ok = ok_q;
  assign o_ok_cnt = ok_cnt_q;
  assign o_err_cnt = err_cnt_q;
endmodule
